// File: rtl/tmds_if.sv
// Pixel-side bundle for the TMDS encoder: sync/enable/pixel in,
// three 10-bit channel symbols out.
interface tmds_if;
    logic        vde;
    logic        hsync;
    logic        vsync;
    logic [23:0] i_data;
    logic [9:0]  tmds_b;
    logic [9:0]  tmds_g;
    logic [9:0]  tmds_r;

    modport master (
        output vde, hsync, vsync, i_data,
        input  tmds_b, tmds_g, tmds_r
    );

    modport slave (
        input  vde, hsync, vsync, i_data,
        output tmds_b, tmds_g, tmds_r
    );
endinterface

// File: rtl/tmds_encoder.sv
// Three-channel DVI TMDS encoder: registered transition minimisation,
// then registered DC balancing with a per-channel running disparity.
module tmds_encoder #(
    parameter bit MONO = 1'b1
) (
    input  logic   pclk,
    input  logic   reset,
    tmds_if.slave  bus
);

    localparam logic [9:0] TOK00 = 10'b1101010100;

    function automatic logic [9:0] f_token(input logic [1:0] ctl);
        logic [9:0] tok;
        unique case (ctl)
            2'b00: tok = 10'b1101010100;
            2'b01: tok = 10'b0010101011;
            2'b10: tok = 10'b0101010100;
            2'b11: tok = 10'b1010101011;
        endcase
        return tok;
    endfunction

    logic r_de;
    logic r_hs;
    logic r_vs;

    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            r_de <= 1'b0;
            r_hs <= 1'b0;
            r_vs <= 1'b0;
        end else begin
            r_de <= bus.vde;
            r_hs <= bus.hsync;
            r_vs <= bus.vsync;
        end
    end

    logic [9:0] w_sym_out [3];

    for (genvar c = 0; c < 3; c++) begin : g_ch
        logic [7:0]        w_din;
        logic [1:0]        w_ctl;
        logic [3:0]        w_n1;
        logic              w_xnor;
        logic [8:0]        w_qm;
        logic [3:0]        w_ones;
        logic signed [4:0] w_bal;
        logic [8:0]        r_qm;
        logic signed [4:0] r_bal;
        logic [9:0]        r_sym;
        logic signed [4:0] r_cnt;
        logic [9:0]        w_sym;
        logic signed [4:0] w_cnt;
        logic signed [4:0] w_q8x2;
        logic signed [4:0] w_nq8x2;

        if (c == 0) begin : g_c0
            assign w_ctl = {r_vs, r_hs};
        end else begin : g_cx
            assign w_ctl = 2'b00;
        end

        if (c == 0 || MONO) begin : g_lo
            assign w_din = bus.i_data[7:0];
        end else begin : g_hi
            assign w_din = bus.i_data[8*c +: 8];
        end

        always_comb begin
            w_n1   = 4'($countones(w_din));
            w_xnor = (w_n1 > 4'd4) || (w_n1 == 4'd4 && !w_din[0]);
            w_qm   = '0;
            w_qm[0] = w_din[0];
            for (int i = 1; i < 8; i++) begin
                w_qm[i] = w_xnor ? ~(w_qm[i-1] ^ w_din[i])
                                 :  (w_qm[i-1] ^ w_din[i]);
            end
            w_qm[8] = ~w_xnor;
            w_ones  = 4'($countones(w_qm[7:0]));
            // N1 - N0 is precomputed here to shorten the stage-2 path
            w_bal   = {w_ones, 1'b0} - 5'd8;
        end

        always_ff @(posedge pclk or posedge reset) begin
            if (reset) begin
                r_qm  <= '0;
                r_bal <= '0;
            end else begin
                r_qm  <= w_qm;
                r_bal <= w_bal;
            end
        end

        assign w_q8x2  = {3'b000, r_qm[8], 1'b0};
        assign w_nq8x2 = {3'b000, ~r_qm[8], 1'b0};

        always_comb begin
            w_sym = TOK00;
            w_cnt = r_cnt;
            if (!r_de) begin
                w_sym = f_token(w_ctl);
                w_cnt = '0;
            end else if (r_cnt == 5'sd0 || r_bal == 5'sd0) begin
                w_sym = {~r_qm[8], r_qm[8],
                         r_qm[8] ? r_qm[7:0] : ~r_qm[7:0]};
                w_cnt = r_cnt + (r_qm[8] ? r_bal : -r_bal);
            end else if (r_cnt[4] == r_bal[4]) begin
                w_sym = {1'b1, r_qm[8], ~r_qm[7:0]};
                w_cnt = r_cnt + w_q8x2 - r_bal;
            end else begin
                w_sym = {1'b0, r_qm[8], r_qm[7:0]};
                w_cnt = r_cnt + r_bal - w_nq8x2;
            end
        end

        always_ff @(posedge pclk or posedge reset) begin
            if (reset) begin
                r_sym <= TOK00;
                r_cnt <= '0;
            end else begin
                r_sym <= w_sym;
                r_cnt <= w_cnt;
            end
        end

        assign w_sym_out[c] = r_sym;
    end

    assign bus.tmds_b = w_sym_out[0];
    assign bus.tmds_g = w_sym_out[1];
    assign bus.tmds_r = w_sym_out[2];

endmodule

// File: tb/tb_tmds_encoder.sv
// Scoreboard bench for tmds_encoder: a mono and a colour instance
// share stimulus and are checked against a behavioural TMDS model.
module tb_tmds_encoder;

    logic pclk = 1'b0;
    logic reset;
    always #5 pclk = ~pclk;

    tmds_if bus_m ();
    tmds_if bus_c ();

    tmds_encoder #(.MONO(1'b1)) dut_m (
        .pclk  (pclk),
        .reset (reset),
        .bus   (bus_m)
    );

    tmds_encoder #(.MONO(1'b0)) dut_c (
        .pclk  (pclk),
        .reset (reset),
        .bus   (bus_c)
    );

    typedef struct {
        int              tag;
        logic            de;
        logic [23:0]     d;
        logic [5:0][9:0] exp;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad = 0;
    int   ecount = 0;
    bit   mon_en = 0;
    int   cnt_m[3];
    int   cnt_c[3];

    always @(posedge pclk) ecount <= ecount + 1;

    task automatic check(input string nm, input logic [9:0] act,
                         input logic [9:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at t=%0t",
                     nm, act, exp, $time);
        end
    endtask

    function automatic logic [9:0] enc(input logic [7:0] d,
                                       input logic de,
                                       input logic [1:0] ctl,
                                       inout int cnt);
        int         n1;
        int         ones;
        int         zeros;
        bit         use_xnor;
        logic [8:0] qm;
        logic [9:0] sym;
        n1 = $countones(d);
        use_xnor = (n1 > 4) || (n1 == 4 && d[0] == 1'b0);
        qm[0] = d[0];
        for (int i = 1; i < 8; i++)
            qm[i] = use_xnor ? (qm[i-1] ~^ d[i]) : (qm[i-1] ^ d[i]);
        qm[8] = !use_xnor;
        ones = $countones(qm[7:0]);
        zeros = 8 - ones;
        if (!de) begin
            cnt = 0;
            case (ctl)
                2'b00: sym = 10'b1101010100;
                2'b01: sym = 10'b0010101011;
                2'b10: sym = 10'b0101010100;
                default: sym = 10'b1010101011;
            endcase
        end else if (cnt == 0 || ones == zeros) begin
            sym = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
            cnt = cnt + (qm[8] ? ones - zeros : zeros - ones);
        end else if ((cnt > 0 && ones > zeros) ||
                     (cnt < 0 && zeros > ones)) begin
            sym = {1'b1, qm[8], ~qm[7:0]};
            cnt = cnt + 2 * int'(qm[8]) + zeros - ones;
        end else begin
            sym = {1'b0, qm[8], qm[7:0]};
            cnt = cnt + ones - zeros - 2 * int'(!qm[8]);
        end
        return sym;
    endfunction

    function automatic logic [7:0] dec(input logic [9:0] s);
        logic [7:0] w;
        logic [7:0] o;
        w = s[9] ? ~s[7:0] : s[7:0];
        o[0] = w[0];
        for (int i = 1; i < 8; i++)
            o[i] = s[8] ? (w[i] ^ w[i-1]) : ~(w[i] ^ w[i-1]);
        return o;
    endfunction

    task automatic set_in(input logic de, input logic h, input logic v,
                          input logic [23:0] d);
        bus_m.vde = de; bus_m.hsync = h; bus_m.vsync = v; bus_m.i_data = d;
        bus_c.vde = de; bus_c.hsync = h; bus_c.vsync = v; bus_c.i_data = d;
    endtask

    task automatic drive(input logic de, input logic h, input logic v,
                         input logic [23:0] d);
        exp_t e;
        int   t;
        logic [1:0] ctl;
        @(negedge pclk);
        set_in(de, h, v, d);
        e.tag = ecount + 1;
        e.de = de;
        e.d = d;
        for (int ch = 0; ch < 3; ch++) begin
            ctl = (ch == 0) ? {v, h} : 2'b00;
            t = cnt_m[ch];
            e.exp[ch] = enc(d[7:0], de, ctl, t);
            cnt_m[ch] = t;
            t = cnt_c[ch];
            e.exp[3+ch] = enc(d[8*ch +: 8], de, ctl, t);
            cnt_c[ch] = t;
        end
        q.push_back(e);
    endtask

    task automatic check_all_reset(input string tag);
        check({tag, "_m_b"}, bus_m.tmds_b, 10'h354);
        check({tag, "_m_g"}, bus_m.tmds_g, 10'h354);
        check({tag, "_m_r"}, bus_m.tmds_r, 10'h354);
        check({tag, "_c_b"}, bus_c.tmds_b, 10'h354);
        check({tag, "_c_g"}, bus_c.tmds_g, 10'h354);
        check({tag, "_c_r"}, bus_c.tmds_r, 10'h354);
    endtask

    always @(posedge pclk) begin
        exp_t e;
        #1;
        if (mon_en) begin
            while (q.size() > 0 && q[0].tag < ecount - 1) begin
                e = q.pop_front();
                total++;
                bad++;
                $display("FAIL missed: entry tag %0d never compared, now %0d",
                         e.tag, ecount);
            end
            if (q.size() > 0 && q[0].tag == ecount - 1) begin
                e = q.pop_front();
                check("m_b", bus_m.tmds_b, e.exp[0]);
                check("m_g", bus_m.tmds_g, e.exp[1]);
                check("m_r", bus_m.tmds_r, e.exp[2]);
                check("c_b", bus_c.tmds_b, e.exp[3]);
                check("c_g", bus_c.tmds_g, e.exp[4]);
                check("c_r", bus_c.tmds_r, e.exp[5]);
                if (e.de) begin
                    check("dec_c_b", {2'b0, dec(bus_c.tmds_b)},
                          {2'b0, e.d[7:0]});
                    check("dec_c_g", {2'b0, dec(bus_c.tmds_g)},
                          {2'b0, e.d[15:8]});
                    check("dec_c_r", {2'b0, dec(bus_c.tmds_r)},
                          {2'b0, e.d[23:16]});
                    check("dec_m_r", {2'b0, dec(bus_m.tmds_r)},
                          {2'b0, e.d[7:0]});
                end
            end
        end
    end

    initial begin
        for (int ch = 0; ch < 3; ch++) begin
            cnt_m[ch] = 0;
            cnt_c[ch] = 0;
        end
        reset = 1'b1;
        set_in(1'b0, 1'b0, 1'b0, 24'h0);
        repeat (3) @(negedge pclk);
        check_all_reset("rst");
        reset = 1'b0;
        mon_en = 1;

        repeat (4) drive(1'b0, 1'b0, 1'b0, 24'h0);
        repeat (2) drive(1'b0, 1'b1, 1'b0, 24'h0);
        repeat (2) drive(1'b0, 1'b0, 1'b1, 24'h0);
        repeat (2) drive(1'b0, 1'b1, 1'b1, 24'h0);
        repeat (2) drive(1'b0, 1'b0, 1'b0, 24'h0);
        repeat (3) drive(1'b1, 1'b0, 1'b0, 24'h000000);
        repeat (2) drive(1'b0, 1'b0, 1'b0, 24'h0);
        repeat (2) drive(1'b1, 1'b0, 1'b0, 24'h0000FF);
        repeat (2) drive(1'b0, 1'b0, 1'b0, 24'h0);
        drive(1'b1, 1'b0, 1'b0, 24'hFF0000);
        repeat (2) drive(1'b0, 1'b1, 1'b0, 24'h0);

        repeat (6) drive(1'b1, 1'b0, 1'b0, 24'($urandom));
        #2;
        mon_en = 0;
        reset = 1'b1;
        #1;
        check_all_reset("arst");
        q.delete();
        for (int ch = 0; ch < 3; ch++) begin
            cnt_m[ch] = 0;
            cnt_c[ch] = 0;
        end
        repeat (2) @(negedge pclk);
        check_all_reset("rsthold");
        set_in(1'b0, 1'b0, 1'b0, 24'h0);
        reset = 1'b0;
        mon_en = 1;
        repeat (3) drive(1'b0, 1'b0, 1'b0, 24'($urandom));

        for (int line = 0; line < 2; line++) begin
            for (int i = 0; i < 40; i++)
                drive(1'b0, 1'($urandom), 1'($urandom), 24'($urandom));
            for (int i = 0; i < 1280; i++)
                drive(1'b1, 1'($urandom), 1'($urandom), 24'($urandom));
        end
        repeat (4) drive(1'b0, 1'b0, 1'b0, 24'h0);
        repeat (3) @(negedge pclk);

        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
